// File: rtl/Shared_pkg.sv
// Shared definitions for the sync FIFO and its write-side arbiter.
package Shared_pkg;
    parameter int FIFO_WIDTH = 16;
    parameter int FIFO_DEPTH = 8;
    parameter int NUM_REQ    = 4;

    typedef enum logic [1:0] {ARB_IDLE, ARB_STREAM, ARB_HOLD} arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning upward from last+1.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan offsets from farthest to nearest so the nearest requester overwrites the rest
    always_comb begin
        idx = '0;
        any = |req;
        for (int off = N; off >= 1; off--) begin
            if (req[(int'(last) + off) % N]) begin
                idx = IW'((int'(last) + off) % N);
            end else begin
                idx = idx;
            end
        end
        for (int j = 0; j < N; j++) begin
            onehot[j] = any && (idx == IW'(j));
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync FIFO write port among NUM_REQ valid/ready producers,
// with full/almostfull throttling and write-ack checking.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = Shared_pkg::NUM_REQ,
    parameter int FIFO_WIDTH = Shared_pkg::FIFO_WIDTH,
    parameter int CNT_W      = 16,
    parameter int IDW        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic [IDW-1:0]                grant_id,
    output logic [NUM_REQ*CNT_W-1:0]      accept_cnt,
    output logic                          err_overflow,
    input  logic                          err_clr
);
    import Shared_pkg::*;

    logic [NUM_REQ-1:0]            pick_onehot_s;
    logic [IDW-1:0]                pick_idx_s;
    logic                          pick_any_s;
    logic                          issue_s;
    logic                          accept_s;
    logic                          err_event_s;

    logic                          fifo_wr_en_q,   fifo_wr_en_d;
    logic [FIFO_WIDTH-1:0]         fifo_data_q,    fifo_data_d;
    logic [IDW-1:0]                grant_id_q,     grant_id_d;
    logic [IDW-1:0]                last_grant_q,   last_grant_d;
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q,          cnt_d;
    logic                          err_q,          err_d;
    logic                          pend_q,         pend_d;
    arb_state_e                    state_q,        state_d;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_pick (
        .req    (req_valid),
        .last   (last_grant_q),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    // Issue gating, handshake and next-state computation
    always_comb begin
        // almostfull leaves one slot, which an in-flight write may already own
        issue_s     = !fifo_full && !(fifo_almostfull && fifo_wr_en_q);
        accept_s    = issue_s && pick_any_s;
        req_ready   = (accept_s && !rst) ? pick_onehot_s : '0;
        err_event_s = fifo_overflow || (pend_q != fifo_wr_ack);

        fifo_wr_en_d = accept_s;
        fifo_data_d  = fifo_data_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        pend_d       = fifo_wr_en_q;
        state_d      = state_q;

        if (accept_s) begin
            fifo_data_d  = req_data[pick_idx_s*FIFO_WIDTH +: FIFO_WIDTH];
            grant_id_d   = pick_idx_s;
            last_grant_d = pick_idx_s;
            if (cnt_q[pick_idx_s] != {CNT_W{1'b1}}) begin
                cnt_d[pick_idx_s] = cnt_q[pick_idx_s] + CNT_W'(1);
            end else begin
                cnt_d[pick_idx_s] = cnt_q[pick_idx_s];
            end
        end else begin
            fifo_data_d = fifo_data_q;
        end

        if (err_event_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ARB_IDLE:   state_d = accept_s ? ARB_STREAM : ARB_IDLE;
            ARB_STREAM: begin
                if (accept_s)        state_d = ARB_STREAM;
                else if (pick_any_s) state_d = ARB_HOLD;
                else                 state_d = ARB_IDLE;
            end
            ARB_HOLD: begin
                if (accept_s)         state_d = ARB_STREAM;
                else if (!pick_any_s) state_d = ARB_IDLE;
                else                  state_d = ARB_HOLD;
            end
            default:    state_d = ARB_IDLE;
        endcase
    end

    // State registers; last_grant resets to the top index so producer 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr_en_q <= 1'b0;
            fifo_data_q  <= '0;
            grant_id_q   <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
            cnt_q        <= '0;
            err_q        <= 1'b0;
            pend_q       <= 1'b0;
            state_q      <= ARB_IDLE;
        end else begin
            fifo_wr_en_q <= fifo_wr_en_d;
            fifo_data_q  <= fifo_data_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            pend_q       <= pend_d;
            state_q      <= state_d;
        end
    end

    assign fifo_wr_en   = fifo_wr_en_q;
    assign fifo_data_in = fifo_data_q;
    assign grant_id     = grant_id_q;
    assign accept_cnt   = cnt_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter with a behavioural arbiter + depth-8 FIFO model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
    logic [1:0]     grant_id;
    logic [N*CW-1:0] accept_cnt;
    logic           err_overflow;
    logic           err_clr;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit         m_wr_en;
    logic [W-1:0] m_data;
    logic [1:0] m_gid;
    int         m_last;
    int         m_cnt [N];
    bit         m_err, m_pend;
    int         f_count;
    bit         f_ack, f_ovf, inj_ovf, rd;

    assign fifo_full       = (f_count == 8);
    assign fifo_almostfull = (f_count == 7);
    assign fifo_wr_ack     = f_ack;
    assign fifo_overflow   = f_ovf | inj_ovf;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
        .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
        .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
        .grant_id(grant_id), .accept_cnt(accept_cnt),
        .err_overflow(err_overflow), .err_clr(err_clr)
    );

    task automatic model_reset();
        m_wr_en = 1'b0; m_data = '0; m_gid = 2'd0; m_last = N - 1;
        m_err = 1'b0; m_pend = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        f_count = 0; f_ack = 1'b0; f_ovf = 1'b0;
    endtask

    // one clock: compare outputs mid-cycle, then advance the model across the edge
    task automatic tick();
        int winner, nc, n_last;
        bit issue, n_wr_en, n_err, n_ack, n_ovf;
        logic [N-1:0] exp_ready;
        logic [W-1:0] n_data;
        logic [1:0] n_gid;
        int n_cnt [N];
        @(negedge clk); #1;
        issue  = (f_count != 8) && !((f_count == 7) && m_wr_en);
        winner = -1;
        for (int off = 1; off <= N; off++)
            if (winner < 0 && req_valid[(m_last + off) % N]) winner = (m_last + off) % N;
        exp_ready = (issue && winner >= 0) ? (4'b0001 << winner) : 4'b0000;

        total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL req_ready: got %b want %b", req_ready, exp_ready); end
        total++; if (fifo_wr_en !== m_wr_en) begin bad++; $display("FAIL wr_en: got %b want %b", fifo_wr_en, m_wr_en); end
        total++; if (fifo_data_in !== m_data) begin bad++; $display("FAIL data_in: got %h want %h", fifo_data_in, m_data); end
        total++; if (grant_id !== m_gid) begin bad++; $display("FAIL grant_id: got %0d want %0d", grant_id, m_gid); end
        total++; if (err_overflow !== m_err) begin bad++; $display("FAIL err_overflow: got %b want %b", err_overflow, m_err); end
        for (int i = 0; i < N; i++) begin
            total++;
            if (accept_cnt[i*CW +: CW] !== CW'(m_cnt[i])) begin
                bad++; $display("FAIL accept_cnt[%0d]: got %0d want %0d", i, accept_cnt[i*CW +: CW], m_cnt[i]);
            end
        end

        n_err = (f_ovf || inj_ovf || (m_pend != f_ack)) ? 1'b1 : (err_clr ? 1'b0 : m_err);
        nc = f_count;
        n_ack = 1'b0; n_ovf = 1'b0;
        if (m_wr_en) begin
            if (f_count < 8) begin nc++; n_ack = 1'b1; end
            else n_ovf = 1'b1;
        end
        if (rd && f_count > 0) nc--;
        for (int i = 0; i < N; i++) n_cnt[i] = m_cnt[i];
        n_wr_en = (issue && winner >= 0);
        n_data = m_data; n_gid = m_gid; n_last = m_last;
        if (n_wr_en) begin
            n_data = req_data[winner*W +: W];
            n_gid  = 2'(winner);
            n_last = winner;
            if (n_cnt[winner] < (1 << CW) - 1) n_cnt[winner]++;
        end
        @(posedge clk); #1;
        m_pend = m_wr_en; m_wr_en = n_wr_en; m_data = n_data; m_gid = n_gid; m_last = n_last;
        m_err = n_err; f_count = nc; f_ack = n_ack; f_ovf = n_ovf;
        for (int i = 0; i < N; i++) m_cnt[i] = n_cnt[i];
    endtask

    task automatic randomize_data();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        hard_reset();
        req_valid = 4'hF; rd = 1'b1; randomize_data();
        tick();
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL first_grant: got %0d want 0", grant_id); end
        tick(); tick();
        #3 rst = 1'b1; #1;
        total++;
        if (req_ready !== 4'b0 || fifo_wr_en !== 1'b0 || fifo_data_in !== 16'h0 || grant_id !== 2'd0 ||
            accept_cnt !== 16'h0 || err_overflow !== 1'b0) begin
            bad++; $display("FAIL async_reset: got rdy=%b we=%b d=%h g=%0d c=%h e=%b want all zero",
                            req_ready, fifo_wr_en, fifo_data_in, grant_id, accept_cnt, err_overflow);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        tick();
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL grant_after_reset: got %0d want 0", grant_id); end
        tick();
    endtask

    task automatic test_all_valid();
        hard_reset();
        req_valid = 4'hF; rd = 1'b1;
        for (int k = 0; k < 8; k++) begin
            randomize_data();
            tick();
            total++; if (grant_id !== 2'(k % 4)) begin bad++; $display("FAIL rotate[%0d]: got %0d want %0d", k, grant_id, k % 4); end
            total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL stream_we[%0d]: got %b want 1", k, fifo_wr_en); end
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (accept_cnt[i*CW +: CW] !== 4'd2) begin bad++; $display("FAIL cnt_two[%0d]: got %0d want 2", i, accept_cnt[i*CW +: CW]); end
        end
    endtask

    task automatic test_single();
        hard_reset();
        req_valid = 4'b0100; rd = 1'b1; randomize_data();
        req_data[2*W +: W] = 16'hA5A5;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (fifo_data_in !== 16'hA5A5 || grant_id !== 2'd2 || fifo_wr_en !== 1'b1) begin
                bad++; $display("FAIL single[%0d]: got d=%h g=%0d we=%b want A5A5/2/1", k, fifo_data_in, grant_id, fifo_wr_en);
            end
        end
        total++;
        if (accept_cnt !== 16'h0600) begin bad++; $display("FAIL single_cnt: got %h want 0600", accept_cnt); end
    endtask

    task automatic test_fill();
        int writes;
        hard_reset();
        rd = 1'b0; writes = 0;
        for (int k = 0; k < 14; k++) begin
            req_valid = 4'($urandom_range(1, 15)); randomize_data();
            tick();
            writes += int'(fifo_wr_en);
        end
        total++; if (writes != 8) begin bad++; $display("FAIL fill_writes: got %0d want 8", writes); end
        total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL fill_err: got %b want 0", err_overflow); end
        rd = 1'b1; tick(); rd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_valid = 4'($urandom_range(1, 15)); randomize_data();
            tick();
        end
    endtask

    task automatic test_error();
        hard_reset();
        req_valid = 4'b0001; rd = 1'b1; randomize_data();
        tick(); tick();
        inj_ovf = 1'b1; tick(); inj_ovf = 1'b0;
        total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", err_overflow); end
        tick(); tick();
        total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL err_hold: got %b want 1", err_overflow); end
        err_clr = 1'b1; inj_ovf = 1'b1; tick(); inj_ovf = 1'b0;
        total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL err_set_wins: got %b want 1", err_overflow); end
        tick(); err_clr = 1'b0;
        total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", err_overflow); end
        tick();
    endtask

    task automatic test_saturation();
        hard_reset();
        req_valid = 4'b0010; rd = 1'b1;
        for (int k = 0; k < 20; k++) begin randomize_data(); tick(); end
        total++; if (accept_cnt[CW +: CW] !== 4'hF) begin bad++; $display("FAIL sat_cnt: got %0d want 15", accept_cnt[CW +: CW]); end
    endtask

    task automatic test_random();
        hard_reset();
        for (int k = 0; k < 300; k++) begin
            req_valid = 4'($urandom); rd = 1'($urandom_range(0, 1)); randomize_data();
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; err_clr = 1'b0; inj_ovf = 1'b0; rd = 1'b0;
        model_reset();
        test_reset();
        test_all_valid();
        test_single();
        test_fill();
        test_error();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
